// File: rtl/frog_lane_engine.sv
// frog_lane_engine: lane-scrolling frog game core. Rows of cars step on a
// divided tick; the frog moves on debounced-edge button presses.
// Ports: clk, reset (async, active-high); up/down/left/right (active-low);
//   lane_map (row r at [r*COLS +: COLS]); frog_row; frog_col (one-hot);
//   game_state (00 PLAY, 01 DEAD, 10 WIN); lives; tick (lane-step pulse).
// Option: define FROG_LIVES_EN for three lives (default build: one life).
module frog_lane_engine #(
  parameter int LANES = 8,
  parameter int COLS = 8,
  parameter int TICK_DIV = 100000000,
  parameter logic [LANES*COLS-1:0] LANE_INIT = '0,
  parameter int START_COL = COLS / 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       up,
  input  logic                       down,
  input  logic                       left,
  input  logic                       right,
  output logic [LANES*COLS-1:0]      lane_map,
  output logic [$clog2(LANES)-1:0]   frog_row,
  output logic [COLS-1:0]            frog_col,
  output logic [1:0]                 game_state,
  output logic [1:0]                 lives,
  output logic                       tick
);

  localparam int RW = $clog2(LANES);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(LANES - 1);
  localparam logic [COLS-1:0] START_OH = COLS'(1) << START_COL;

  // Rows 0 and LANES-1 are safe rows and never hold cars.
  localparam logic [LANES*COLS-1:0] SAFE_MASK =
    {{COLS{1'b0}}, {((LANES-2)*COLS){1'b1}}, {COLS{1'b0}}};
  localparam logic [LANES*COLS-1:0] INIT_ROWS = LANE_INIT & SAFE_MASK;

  localparam int B_UP = 3;
  localparam int B_DN = 2;
  localparam int B_LT = 1;
  localparam int B_RT = 0;

  typedef enum logic [1:0] {
    S_PLAY = 2'b00,
    S_DEAD = 2'b01,
    S_WIN  = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]                cnt;
  logic [LANES-1:0][COLS-1:0]   rows_q;
  logic [LANES-1:0][COLS-1:0]   rows_rot;
  logic [3:0]                   sync1, sync2, sync3;
  logic [3:0]                   press;
  logic [RW-1:0]                row_d;
  logic [COLS-1:0]              col_d;
  logic                         hit;
  logic                         restart;
  logic                         last_life;

  // Lane step timing
  assign tick = (cnt == CNT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Odd rows drift right, even rows drift left
  always_comb begin
    rows_rot = rows_q;
    for (int r = 0; r < LANES; r++) begin
      if (r == 0 || r == LANES - 1) begin
        rows_rot[r] = '0;
      end else if (r % 2 == 1) begin
        rows_rot[r] = {rows_q[r][0], rows_q[r][COLS-1:1]};
      end else begin
        rows_rot[r] = {rows_q[r][COLS-2:0], rows_q[r][COLS-1]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_q <= INIT_ROWS;
    end else if (tick) begin
      rows_q <= rows_rot;
    end
  end

  assign lane_map = rows_q;

  // Two-flop synchroniser plus a history flop; idle level is high, so
  // resetting all three to 1 keeps release from looking like a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
      sync3 <= '1;
    end else begin
      sync1 <= {up, down, left, right};
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign press = sync3 & ~sync2;

  assign hit = (state_q == S_PLAY) &&
               (|(rows_q[frog_row] & frog_col));

  assign restart = (state_q == S_DEAD || state_q == S_WIN) && (|press);

  // Game FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_PLAY;
      frog_row <= LAST_ROW;
      frog_col <= START_OH;
    end else begin
      state_q  <= state_d;
      frog_row <= row_d;
      frog_col <= col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = frog_row;
    col_d   = frog_col;
    case (state_q)
      S_PLAY: begin
        if (hit) begin
          if (last_life) begin
            state_d = S_DEAD;
          end else begin
            row_d = LAST_ROW;
            col_d = START_OH;
          end
        end else if (frog_row == '0) begin
          state_d = S_WIN;
        end else if (press[B_UP]) begin
          row_d = frog_row - 1'b1;
        end else if (press[B_DN]) begin
          if (frog_row != LAST_ROW) begin
            row_d = frog_row + 1'b1;
          end
        end else if (press[B_LT]) begin
          if (!frog_col[COLS-1]) begin
            col_d = frog_col << 1;
          end
        end else if (press[B_RT]) begin
          if (!frog_col[0]) begin
            col_d = frog_col >> 1;
          end
        end
      end
      S_DEAD, S_WIN: begin
        if (restart) begin
          state_d = S_PLAY;
          row_d   = LAST_ROW;
          col_d   = START_OH;
        end
      end
      default: begin
        state_d = S_PLAY;
      end
    endcase
  end

  assign game_state = state_q;

`ifdef FROG_LIVES_EN
  localparam logic [1:0] RELOAD = 2'd3;

  logic [1:0] lives_q, lives_d;

  assign last_life = (lives_q <= 2'd1);

  always_comb begin
    lives_d = lives_q;
    if (restart) begin
      lives_d = RELOAD;
    end else if (hit) begin
      lives_d = last_life ? 2'd0 : lives_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lives_q <= RELOAD;
    end else begin
      lives_q <= lives_d;
    end
  end

  assign lives = lives_q;
`else
  // Single life: the count follows the state directly.
  assign last_life = 1'b1;
  assign lives = (state_q == S_DEAD) ? 2'd0 : 2'd1;
`endif

endmodule

// File: tb/tb_frog_lane_engine.sv
// tb_frog_lane_engine: scoreboard bench for frog_lane_engine on a 4x4 grid
// with a 4-cycle tick; car timing comes from a small lane model.
module tb_frog_lane_engine;

  localparam int LANES = 4;
  localparam int COLS = 4;
  localparam int TD = 4;
  localparam logic [15:0] INIT = 16'h0180;
  localparam logic [3:0] START = 4'b0100;
`ifdef FROG_LIVES_EN
  localparam logic [1:0] RELOAD = 2'd3;
`else
  localparam logic [1:0] RELOAD = 2'd1;
`endif

  localparam logic [3:0] M_UP = 4'b1000;
  localparam logic [3:0] M_DN = 4'b0100;
  localparam logic [3:0] M_LT = 4'b0010;
  localparam logic [3:0] M_RT = 4'b0001;

  localparam logic [1:0] PLAY = 2'b00;
  localparam logic [1:0] DEAD = 2'b01;
  localparam logic [1:0] WIN  = 2'b10;

  logic        clk, reset;
  logic        up, down, left, right;
  logic [15:0] lane_map;
  logic [1:0]  frog_row;
  logic [3:0]  frog_col;
  logic [1:0]  game_state;
  logic [1:0]  lives;
  logic        tick;

  int n_cmp;
  int n_bad;
  bit mon_en;

  frog_lane_engine #(
    .LANES(LANES),
    .COLS(COLS),
    .TICK_DIV(TD),
    .LANE_INIT(INIT),
    .START_COL(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .up(up),
    .down(down),
    .left(left),
    .right(right),
    .lane_map(lane_map),
    .frog_row(frog_row),
    .frog_col(frog_col),
    .game_state(game_state),
    .lives(lives),
    .tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Lane model: row 1 car drifts right, row 2 car drifts left
  int         mcnt;
  logic [3:0] m1, m2;

  function automatic logic [3:0] ror1(input logic [3:0] x);
    return {x[0], x[3:1]};
  endfunction

  function automatic logic [3:0] rol1(input logic [3:0] x);
    return {x[2:0], x[3]};
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mcnt <= 0;
      m1   <= 4'b1000;
      m2   <= 4'b0001;
    end else if (mcnt == TD - 1) begin
      mcnt <= 0;
      m1   <= ror1(m1);
      m2   <= rol1(m2);
    end else begin
      mcnt <= mcnt + 1;
    end
  end

  // Row r as it will look after k more rising edges
  function automatic logic [3:0] future(input int r, input int k);
    logic [3:0] x;
    int n;
    n = (mcnt + k) / TD;
    x = (r == 1) ? m1 : m2;
    for (int i = 0; i < n; i++) begin
      x = (r == 1) ? ror1(x) : rol1(x);
    end
    return x;
  endfunction

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      check("lanes", lane_map, {4'b0000, m2, m1, 4'b0000});
      check("tick", tick, (mcnt == TD - 1));
    end
  end

  // Scoreboard
  typedef struct packed {
    bit         full;
    logic [1:0] row;
    logic [3:0] col;
    logic [1:0] st;
    logic [1:0] lv;
  } exp_t;

  exp_t sb[$];

  task automatic push_exp(input bit full, input logic [1:0] row,
                          input logic [3:0] col, input logic [1:0] st,
                          input logic [1:0] lv);
    exp_t e;
    e.full = full;
    e.row  = row;
    e.col  = col;
    e.st   = st;
    e.lv   = lv;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    check({tag, "_depth"}, sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.full) begin
        check({tag, "_row"}, frog_row, e.row);
        check({tag, "_col"}, frog_col, e.col);
      end
      check({tag, "_state"}, game_state, e.st);
      check({tag, "_lives"}, lives, e.lv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Button pulse: the move lands on the third rising edge after driving
  task automatic tap(input logic [3:0] m);
    {up, down, left, right} = ~m;
    step(1);
    {up, down, left, right} = 4'hf;
    step(2);
  endtask

  function automatic bit safe_run();
    for (int k = 3; k <= 13; k++) begin
      if ((future(2, k) & START) != 0) return 1'b0;
    end
    for (int k = 14; k <= 16; k++) begin
      if ((future(1, k) & START) != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic wait_hit(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if ((future(2, 3) & START) != 0) found = 1'b1;
      else step(1);
    end
    check({tag, "_window"}, found, 1);
  endtask

  task automatic kill_all(input string tag);
    for (int h = 1; h <= int'(RELOAD); h++) begin
      wait_hit(tag);
      if (h < int'(RELOAD)) push_exp(1, 2'd3, START, PLAY, 2'(int'(RELOAD) - h));
      else push_exp(0, 2'd0, 4'd0, DEAD, 2'd0);
      tap(M_UP);
      step(2);
      pop_cmp($sformatf("%s_hit%0d", tag, h));
    end
  endtask

  logic [3:0] mv_seq [8];
  logic [3:0] col_seq [8];

  initial begin
    bit found;
    n_cmp  = 0;
    n_bad  = 0;
    mon_en = 1'b0;
    {up, down, left, right} = 4'hf;
    reset = 1'b1;
    mv_seq  = '{M_LT, M_LT, M_RT, M_RT, M_RT, M_RT, M_LT, M_LT};
    col_seq = '{4'b1000, 4'b1000, 4'b0100, 4'b0010,
                4'b0001, 4'b0001, 4'b0010, 4'b0100};
    step(2);

    check("rst_lanes", lane_map, INIT);
    check("rst_row", frog_row, 2'd3);
    check("rst_col", frog_col, START);
    check("rst_state", game_state, PLAY);
    check("rst_lives", lives, RELOAD);
    check("rst_tick", tick, 0);

    reset  = 1'b0;
    mon_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step(1);
      check($sformatf("tick_c%0d", i), tick, (i == 3));
    end
    check("lanes_tick1", lane_map, 16'h0240);

    push_exp(1, 2'd3, START, PLAY, RELOAD);
    pop_cmp("idle");

    push_exp(1, 2'd3, START, PLAY, RELOAD);
    tap(M_DN);
    pop_cmp("down_sat");

    for (int i = 0; i < 8; i++) begin
      push_exp(1, 2'd3, col_seq[i], PLAY, RELOAD);
      tap(mv_seq[i]);
      pop_cmp($sformatf("col%0d", i));
    end

    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (safe_run()) found = 1'b1;
      else step(1);
    end
    check("run_window", found, 1);

    push_exp(1, 2'd2, START, PLAY, RELOAD);
    up = 1'b0;
    step(10);
    up = 1'b1;
    pop_cmp("hold_up");
    step(1);

    push_exp(1, 2'd1, START, PLAY, RELOAD);
    tap(M_UP | M_LT);
    pop_cmp("prio");

    push_exp(1, 2'd0, START, PLAY, RELOAD);
    tap(M_UP);
    pop_cmp("row0");

    push_exp(1, 2'd0, START, WIN, RELOAD);
    step(1);
    pop_cmp("win");

    push_exp(1, 2'd3, START, PLAY, RELOAD);
    tap(M_RT);
    pop_cmp("win_restart");

    kill_all("k1");

    push_exp(1, 2'd3, START, PLAY, RELOAD);
    tap(M_UP);
    pop_cmp("dead_restart");

    kill_all("k2");

    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_lanes", lane_map, INIT);
    check("mid_row", frog_row, 2'd3);
    check("mid_col", frog_col, START);
    check("mid_state", game_state, PLAY);
    check("mid_lives", lives, RELOAD);
    check("mid_tick", tick, 0);
    step(2);
    reset = 1'b0;

    push_exp(1, 2'd3, START, PLAY, RELOAD);
    step(4);
    pop_cmp("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frog_lane_engine.md
FROG_LANE_ENGINE -- requirements
Module: frog_lane_engine

Interface
REQ-001 SHALL have parameter LANES, default 8: number of rows; row 0 is the goal (top) and row LANES-1 is the start (bottom); LANES >= 3.
REQ-002 SHALL have parameter COLS, default 8: columns per row; bit COLS-1 is the leftmost column; COLS >= 2.
REQ-003 SHALL have parameter TICK_DIV, default 100000000: clk cycles per lane step; TICK_DIV >= 2.
REQ-004 SHALL have parameter LANE_INIT, default all zero: a LANES*COLS flat vector giving each row's car pattern at reset; row r occupies bits [r*COLS +: COLS].
REQ-005 SHALL have parameter START_COL, default COLS/2: the frog's start column index.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have ports up, down, left, right, input, 1 bit each: active-low buttons, asynchronous to game state.
REQ-009 SHALL have port lane_map, output, LANES*COLS bits: current car occupancy, same packing as LANE_INIT.
REQ-010 SHALL have port frog_row, output, $clog2(LANES) bits: the frog's row index.
REQ-011 SHALL have port frog_col, output, COLS bits: the frog's column, one-hot.
REQ-012 SHALL have port game_state, output, 2 bits: 00 PLAY, 01 DEAD, 10 WIN.
REQ-013 SHALL have port lives, output, 2 bits: remaining lives.
REQ-014 SHALL have port tick, output, 1 bit: single-cycle pulse on each lane step.

Function
REQ-015 SHALL run a tick counter from 0 to TICK_DIV-1, wrap to 0, and assert tick for the one cycle when the count equals TICK_DIV-1.
REQ-016 SHALL, on tick: rotate odd rows right by 1, rotate even rows left by 1, and force rows 0 and LANES-1 to zero (safe rows).
REQ-017 SHALL synchronise each button through two flops and detect a press only on a 1->0 transition of the synchronised level; a held button produces exactly one move.
REQ-018 SHALL, when several presses are detected in the same cycle, apply only the highest-priority one: up > down > left > right.
REQ-019 SHALL apply moves in PLAY only: up decrements frog_row, down increments it, left shifts frog_col toward the MSB, right shifts it toward the LSB.
REQ-020 SHALL saturate every move at the grid edges: no wrap of row or column.
REQ-021 SHALL detect a hit in PLAY when (row frog_row of lane_map) & frog_col is non-zero; the hit is evaluated on registered values and takes effect on the next clock edge.
REQ-022 SHALL, on a hit, decrement lives and return the frog to row LANES-1, column START_COL; if lives was 1, it SHALL instead enter DEAD with lives = 0. Hit handling SHALL take precedence over any move detected in the same cycle.
REQ-023 SHALL enter WIN on the edge after frog_row becomes 0 while in PLAY.
REQ-024 SHALL, in DEAD or WIN, ignore moves while lanes keep stepping; any detected press SHALL restart the game: state PLAY, frog at the start position, lives reloaded, lanes not reset.
REQ-025 SHALL never encode game_state 11; if 11 occurs, it SHALL recover to PLAY on the next edge.

Reset
REQ-026 SHALL, with reset high and regardless of clk, set: lane_map = LANE_INIT with rows 0 and LANES-1 zeroed, frog_row = LANES-1, frog_col = one-hot START_COL, game_state = PLAY, lives = reload value, tick = 0, tick counter = 0, synchroniser flops = 1 (released).
REQ-027 SHALL NOT, on reset release, generate a spurious press while the buttons are idle high.

Configuration
REQ-028 SHALL, when macro FROG_LIVES_EN is defined, use a lives reload value of 3 and follow the REQ-022 decrement behaviour.
REQ-029 SHALL, without FROG_LIVES_EN, use a reload value of 1 and tie lives to 1 except in DEAD, where it is 0; the first hit enters DEAD.

Verification
REQ-030 SHALL cover tick and rotation: LANES=4, COLS=4, TICK_DIV=4, row 1 init 1000, row 2 init 0001 -> tick every 4th cycle; row 1 goes 1000->0100 and row 2 goes 0001->0010 after the first tick.
REQ-031 SHALL cover single press and priority: up held low for 10 cycles -> frog_row decrements by exactly 1; up and left pressed in the same cycle -> only the row changes.
REQ-032 SHALL cover saturation: frog_col = 1000, left pressed -> frog_col stays 1000; frog_row = LANES-1, down pressed -> row unchanged.
REQ-033 SHALL cover hit and lives with FROG_LIVES_EN: frog moved onto an occupied cell -> lives 3->2 and frog at start; after three hits -> game_state = 01, lives = 0.
REQ-034 SHALL cover win and restart: frog walked to row 0 through empty lanes -> game_state = 10; any press -> game_state = 00 and frog_row = LANES-1.
REQ-035 SHALL cover reset mid-game: reset asserted between clock edges during DEAD -> all outputs take their REQ-026 values immediately.
